mbist_march_ctrl: RTL and testbench

March C- sequencing controller for the SRAM BIST datapath: generates SRAM address, chip-enable, write-enable and write data, and checks read data one cycle later. Directly upstream of the `MBIST_Mux41` background selector: drives the mux `sel` through `bg_sel` and takes the mux output back as `bg_data`. Runs the full March C- pass once per data background (0, 1, 2, 3 in order) and reports pass/fail with the first failing location.

---
 rtl/mbist_pkg.sv | 12 +
 rtl/mbist_addr_gen.sv | 34 +++
 rtl/mbist_march_ctrl.sv | 133 +++++++++++++
 tb/tb_mbist_march_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/mbist_pkg.sv
// mbist_pkg: shared encodings for the March C- BIST controller and background mux.
package mbist_pkg;
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;
    typedef enum logic [2:0] {M0, M1, M2, M3, M4, M5} elem_t;
    localparam logic [1:0] BG_ZERO = 2'd0;
    localparam logic [1:0] BG_ONE  = 2'd1;
    localparam logic [1:0] BG_CHK  = 2'd2;
    localparam logic [1:0] BG_ICHK = 2'd3;
    function automatic logic elem_pair(elem_t e);
        return e inside {M1, M2, M3, M4};
    endfunction
endpackage

// File: rtl/mbist_addr_gen.sv
// mbist_addr_gen: up/down address counter with load-to-bound and last-address flag.
module mbist_addr_gen #(
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_i,
    input  logic                  load_down_i,
    input  logic                  step_i,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic                  last_o
);
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic down_q, down_d;

    always_comb begin
        addr_d = load_i ? (load_down_i ? '1 : '0)
               : step_i ? (down_q ? addr_q - 1'b1 : addr_q + 1'b1) : addr_q;
        down_d = load_i ? load_down_i : down_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
            down_q <= 1'b0;
        end else begin
            addr_q <= addr_d;
            down_q <= down_d;
        end
    end

    assign addr_o = addr_q;
    assign last_o = down_q ? (addr_q == '0) : (addr_q == '1);
endmodule

// File: rtl/mbist_march_ctrl.sv
// mbist_march_ctrl: March C- sequencer over four data backgrounds with a
// one-cycle read compare pipeline and first-failure capture.
module mbist_march_ctrl
    import mbist_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] bg_data,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [1:0]            bg_sel,
    output logic                  mem_ce,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  fail,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [1:0]            fail_bg
);
    state_t state_q, state_d;
    elem_t  elem_q, elem_d;
    logic phase_q, phase_d;
    logic [1:0] bg_q, bg_d;
    logic ld, ld_down, stp, last, run, rd, one, op_end, launch;
    logic rd_vld_q, fail_q;
    logic [DATA_WIDTH-1:0] exp_q;
    logic [ADDR_WIDTH-1:0] cmp_addr_q, fail_addr_q, addr;
    logic [1:0] cmp_bg_q, fail_bg_q;

    mbist_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_addr (
        .clk(clk), .rst_n(rst_n), .load_i(ld), .load_down_i(ld_down),
        .step_i(stp), .addr_o(addr), .last_o(last)
    );

    assign run    = state_q == S_RUN;
    assign launch = (state_q == S_IDLE || state_q == S_DONE) && start;
    // Phase 0 of a pair is the read; M0 is write-only and M5 read-only.
    assign rd     = elem_q != M0 && !phase_q;
    assign one    = (elem_q == M1 || elem_q == M3) ? phase_q
                  : (elem_q == M2 || elem_q == M4) ? !phase_q : 1'b0;
    assign op_end = elem_pair(elem_q) ? phase_q : 1'b1;

    always_comb begin
        state_d = state_q;
        elem_d  = elem_q;
        phase_d = phase_q;
        bg_d    = bg_q;
        ld      = 1'b0;
        ld_down = 1'b0;
        stp     = 1'b0;
        if (launch) begin
            state_d = S_RUN;
            elem_d  = M0;
            phase_d = 1'b0;
            bg_d    = BG_ZERO;
            ld      = 1'b1;
        end else if (state_q == S_DRAIN) begin
            state_d = S_DONE;
        end else if (run) begin
            phase_d = !op_end;
            if (op_end && !last) begin
                stp = 1'b1;
            end else if (op_end && elem_q != M5) begin
                elem_d  = elem_t'(elem_q + 3'd1);
                ld      = 1'b1;
                ld_down = elem_q >= M2;
            end else if (op_end && bg_q != BG_ICHK) begin
                bg_d   = bg_q + 2'd1;
                elem_d = M0;
                ld     = 1'b1;
            end else if (op_end) begin
                state_d = S_DRAIN;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            elem_q  <= M0;
            phase_q <= 1'b0;
            bg_q    <= BG_ZERO;
        end else begin
            state_q <= state_d;
            elem_q  <= elem_d;
            phase_q <= phase_d;
            bg_q    <= bg_d;
        end
    end

    // During a read, mem_wdata already holds the expected word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_vld_q    <= 1'b0;
            exp_q       <= '0;
            cmp_addr_q  <= '0;
            cmp_bg_q    <= '0;
            fail_q      <= 1'b0;
            fail_addr_q <= '0;
            fail_bg_q   <= '0;
        end else begin
            rd_vld_q   <= run && rd;
            exp_q      <= mem_wdata;
            cmp_addr_q <= addr;
            cmp_bg_q   <= bg_q;
            if (launch) begin
                fail_q      <= 1'b0;
                fail_addr_q <= '0;
                fail_bg_q   <= '0;
            end else if (rd_vld_q && mem_rdata != exp_q && !fail_q) begin
                fail_q      <= 1'b1;
                fail_addr_q <= cmp_addr_q;
                fail_bg_q   <= cmp_bg_q;
            end
        end
    end

    assign bg_sel    = bg_q;
    assign mem_ce    = run;
    assign mem_we    = run && !rd;
    assign mem_addr  = addr;
    assign mem_wdata = (run && one) ? ~bg_data : bg_data;
    assign busy      = run || state_q == S_DRAIN;
    assign done      = state_q == S_DONE;
    assign fail      = fail_q;
    assign fail_addr = fail_addr_q;
    assign fail_bg   = fail_bg_q;
endmodule

// File: tb/tb_mbist_march_ctrl.sv
// tb_mbist_march_ctrl: randomized March C- checks against a behavioural op-list and memory model.
module tb_mbist_march_ctrl;
    localparam int AW = 4, DW = 8, D = 16, N = 40 * D;
    localparam int R0 = 0, R1 = 1, W0 = 2, W1 = 3, NOP = -1;

    logic clk = 0, rst_n = 0, start = 0;
    logic [DW-1:0] bg_data, mem_rdata = '0, mem_wdata;
    logic [1:0] bg_sel, fail_bg;
    logic mem_ce, mem_we, busy, done, fail;
    logic [AW-1:0] mem_addr, fail_addr;

    mbist_march_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .bg_data(bg_data),
        .mem_rdata(mem_rdata), .bg_sel(bg_sel), .mem_ce(mem_ce), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy), .done(done),
        .fail(fail), .fail_addr(fail_addr), .fail_bg(fail_bg)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] bg_tab [4];
    assign bg_data = bg_tab[bg_sel];

    bit f_en;
    int f_addr, f_bit;
    bit f_val;
    logic [DW-1:0] mem [D];

    function automatic logic [DW-1:0] stick(logic [DW-1:0] w, int a);
        logic [DW-1:0] r = w;
        if (f_en && a == f_addr) r[f_bit] = f_val;
        return r;
    endfunction

    always @(posedge clk)
        if (mem_ce) begin
            if (mem_we) mem[mem_addr] <= stick(mem_wdata, int'(mem_addr));
            else mem_rdata <= mem[mem_addr];
        end

    typedef struct {bit we; int addr; logic [DW-1:0] data; int bg;} op_t;
    op_t exp_ops[$];
    bit e_fail;
    int e_faddr, e_fbg;
    int total = 0, bad = 0;
    int march [6][2] = '{'{W0, NOP}, '{R0, W1}, '{R1, W0}, '{R0, W1}, '{R1, W0}, '{R0, NOP}};

    task automatic build_model();
        logic [DW-1:0] m [D];
        exp_ops.delete();
        e_fail = 0; e_faddr = 0; e_fbg = 0;
        for (int b = 0; b < 4; b++)
            for (int e = 0; e < 6; e++)
                for (int k = 0; k < D; k++)
                    for (int j = 0; j < 2; j++) begin
                        int a, c;
                        logic [DW-1:0] w;
                        op_t o;
                        c = march[e][j];
                        if (c == NOP) continue;
                        a = (e < 3) ? k : D - 1 - k;
                        w = (c == R1 || c == W1) ? ~bg_tab[b] : bg_tab[b];
                        if (c >= W0) m[a] = stick(w, a);
                        else if (m[a] !== w && !e_fail) begin
                            e_fail = 1; e_faddr = a; e_fbg = b;
                        end
                        o.we = c >= W0; o.addr = a; o.data = w; o.bg = b;
                        exp_ops.push_back(o);
                    end
    endtask

    task automatic randomize_bgs();
        for (int b = 0; b < 4; b++) bg_tab[b] = DW'($urandom);
    endtask

    task automatic run_and_check(string name, bit hold);
        build_model();
        @(negedge clk); start = 1;
        @(negedge clk); start = hold;
        if (fail !== 1'b0) begin
            bad++; $display("FAIL %s fail_on_entry got=%0b want=0", name, fail);
        end
        total++;
        for (int i = 0; i < N; i++) begin
            op_t o = exp_ops[i];
            total++;
            if (busy !== 1 || mem_ce !== 1 || mem_we !== o.we || int'(mem_addr) != o.addr ||
                int'(bg_sel) != o.bg || (o.we && mem_wdata !== o.data)) begin
                bad++;
                $display("FAIL %s op%0d got we=%0b addr=%0d bg=%0d wd=%h busy=%0b ce=%0b want we=%0b addr=%0d bg=%0d wd=%h",
                         name, i, mem_we, mem_addr, bg_sel, mem_wdata, busy, mem_ce, o.we, o.addr, o.bg, o.data);
            end
            @(negedge clk);
        end
        start = 0;
        total++;
        if (done !== 0 || busy !== 1 || mem_ce !== 0) begin
            bad++; $display("FAIL %s drain got done=%0b busy=%0b ce=%0b want 0 1 0", name, done, busy, mem_ce);
        end
        @(negedge clk);
        total++;
        if (done !== 1 || busy !== 0) begin
            bad++; $display("FAIL %s done_at_641 got done=%0b busy=%0b want 1 0", name, done, busy);
        end
        total++;
        if (fail !== e_fail || (e_fail && (int'(fail_addr) != e_faddr || int'(fail_bg) != e_fbg))) begin
            bad++;
            $display("FAIL %s status got fail=%0b addr=%0d bg=%0d want fail=%0b addr=%0d bg=%0d",
                     name, fail, fail_addr, fail_bg, e_fail, e_faddr, e_fbg);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        total++;
        if ({bg_sel, mem_ce, mem_we, mem_addr, busy, done, fail, fail_addr, fail_bg} !== '0 ||
            mem_wdata !== bg_data) begin
            bad++; $display("FAIL reset got sel=%0d ce=%0b we=%0b addr=%0d busy=%0b done=%0b fail=%0b want all 0",
                            bg_sel, mem_ce, mem_we, mem_addr, busy, done, fail);
        end
        rst_n = 1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_clean();
        f_en = 0;
        for (int r = 0; r < 2; r++) begin
            randomize_bgs();
            run_and_check("clean", 0);
            repeat ($urandom_range(0, 4)) @(negedge clk);
        end
    endtask

    task automatic test_stuck_bit3();
        randomize_bgs();
        bg_tab[0] = 8'h00;
        f_en = 1; f_addr = 5; f_bit = 3; f_val = 0;
        run_and_check("stuck_a5_b3", 0);
        total++;
        if (fail !== 1 || fail_addr !== 4'd5 || fail_bg !== 2'd0) begin
            bad++; $display("FAIL stuck_fixed got fail=%0b addr=%0d bg=%0d want 1 5 0", fail, fail_addr, fail_bg);
        end
    endtask

    task automatic test_random_faults();
        for (int r = 0; r < 4; r++) begin
            randomize_bgs();
            f_en = 1; f_addr = $urandom_range(0, D - 1); f_bit = $urandom_range(0, DW - 1);
            f_val = 1'($urandom);
            run_and_check("rand_fault", 0);
        end
    endtask

    task automatic test_restart_clean();
        f_en = 1; f_addr = 9; f_bit = 0; f_val = 1;
        randomize_bgs();
        run_and_check("pre_restart", 0);
        f_en = 0;
        run_and_check("restart", 0);
    endtask

    task automatic test_start_held();
        f_en = 0;
        randomize_bgs();
        run_and_check("start_held", 1);
    endtask

    task automatic test_reset_mid();
        f_en = 1; f_addr = 5; f_bit = 3; f_val = 0;
        bg_tab[0] = 8'h00;
        @(negedge clk); start = 1;
        @(negedge clk); start = 0;
        repeat (299) @(negedge clk);
        #2 rst_n = 0;
        #1;
        total++;
        if ({bg_sel, mem_ce, mem_we, mem_addr, busy, done, fail, fail_addr, fail_bg} !== '0) begin
            bad++; $display("FAIL reset_mid got sel=%0d ce=%0b addr=%0d busy=%0b done=%0b fail=%0b want all 0",
                            bg_sel, mem_ce, mem_addr, busy, done, fail);
        end
        @(negedge clk); rst_n = 1;
        repeat (20) @(negedge clk);
        total++;
        if (busy !== 0 || done !== 0 || mem_ce !== 0 || fail !== 0) begin
            bad++; $display("FAIL idle_hold got busy=%0b done=%0b ce=%0b fail=%0b want 0", busy, done, mem_ce, fail);
        end
        f_en = 0;
        randomize_bgs();
        run_and_check("after_reset", 0);
    endtask

    initial begin
        f_en = 0;
        bg_tab = '{8'h00, 8'hFF, 8'h55, 8'hAA};
        for (int a = 0; a < D; a++) mem[a] = DW'($urandom);
        test_reset();
        test_clean();
        test_stuck_bit3();
        test_random_faults();
        test_restart_clean();
        test_start_held();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
